// File: rtl/data_mem_responder_pkg.sv
// Shared types and defaults for the CPU data-memory responder.
// Holds the FSM state encoding and the data-path width defaults.
package data_mem_responder_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LANES_DEF  = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_sp_ram_be.sv
// Single-port RAM with synchronous byte-enabled write and async read,
// plus an independent async debug read port.
module sp_ram_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    input  logic [ADDR_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0]   dbg_rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata     = mem[addr];
    assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts wait
// states, then pulses ack (with err) and serves data from an on-chip RAM.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_be,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              mem_err,
    output logic              busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              l_we;
    logic [3:0]        l_be;
    logic [31:0]       l_addr;
    logic [DATA_W-1:0] l_wdata;

    logic              idle;
    logic              c_we;
    logic [3:0]        c_be;
    logic [31:0]       c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_err;
    logic              go_resp;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // With zero wait states RESP is entered on the acceptance edge itself,
    // so the live inputs stand in for the not-yet-latched request.
    always_comb begin
        idle    = (state == ST_IDLE);
        c_we    = idle ? mem_we    : l_we;
        c_be    = idle ? mem_be    : l_be;
        c_addr  = idle ? mem_addr  : l_addr;
        c_wdata = idle ? mem_wdata : l_wdata;
        c_err   = (|c_addr[31:ADDR_W+2])
                | ((|c_addr[1:0]) & (c_be == 4'hF));
        go_resp = (idle & mem_req & (WAIT_CYCLES == 0))
                | ((state == ST_WAIT) & (cnt == CNT_LAST));
        ram_we  = go_resp & c_we & ~c_err;
    end

    sp_ram_be #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .we        (ram_we),
        .be        (c_be),
        .addr      (c_addr[ADDR_W+1:2]),
        .wdata     (c_wdata),
        .rdata     (ram_rdata),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            l_we      <= 1'b0;
            l_be      <= '0;
            l_addr    <= '0;
            l_wdata   <= '0;
            mem_rdata <= '0;
            mem_ack   <= 1'b0;
            mem_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_ack   <= go_resp;
            mem_err   <= go_resp & c_err;
            mem_rdata <= (go_resp & ~c_we & ~c_err) ? ram_rdata : '0;
            unique case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        l_we    <= mem_we;
                        l_be    <= mem_be;
                        l_addr  <= mem_addr;
                        l_wdata <= mem_wdata;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= ST_RESP;
                    end else if (cnt != 4'hF) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
